primitive_assembler: RTL and testbench

- Parametrised successor to the fixed triangle-list assembler.
- Pops packed vertices from the vertex FIFO (1-cycle registered read latency) and assembles them into triangles.
- Supports list, strip and fan topologies, primitive restart and output backpressure.
- Sits between vertex_fifo and the rasterizer; field widths are generic.

---
 rtl/primitive_assembler.sv | 191 +++++++++++++++++++
 tb/tb_primitive_assembler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/primitive_assembler.sv
// primitive_assembler: pops packed vertices {x,y,z,u,v} from the vertex FIFO
// and assembles list / strip / fan triangles for the rasterizer.
// Optional back-face / degenerate culling is built when ASM_CULL_EN is defined.
module primitive_assembler #(
   parameter int XW   = 16,
   parameter int ZW   = 8,
   parameter int UVW  = 32,
   parameter int CNTW = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [2*XW+ZW+2*UVW-1:0] i_fifo_data,
   input  logic                     i_fifo_empty,
   output logic                     o_fifo_read,
   input  logic [1:0]               i_mode,
   input  logic                     i_restart,
   output logic                     o_tri_valid,
   input  logic                     i_raster_busy,
   output logic signed [XW-1:0]     o_x0,
   output logic signed [XW-1:0]     o_y0,
   output logic signed [XW-1:0]     o_x1,
   output logic signed [XW-1:0]     o_y1,
   output logic signed [XW-1:0]     o_x2,
   output logic signed [XW-1:0]     o_y2,
   output logic [ZW-1:0]            o_z0,
   output logic [ZW-1:0]            o_z1,
   output logic [ZW-1:0]            o_z2,
   output logic [UVW-1:0]           o_u0,
   output logic [UVW-1:0]           o_v0,
   output logic [UVW-1:0]           o_u1,
   output logic [UVW-1:0]           o_v1,
   output logic [UVW-1:0]           o_u2,
   output logic [UVW-1:0]           o_v2,
   output logic [CNTW-1:0]          o_tri_count,
   output logic [CNTW-1:0]          o_cull_count
);

   localparam int VW = 2*XW+ZW+2*UVW;

`ifdef ASM_CULL_EN
   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_CULL, S_EMIT} state_t;
`else
   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EMIT} state_t;
`endif
   typedef enum logic [1:0] {M_LIST = 2'd0, M_STRIP = 2'd1, M_FAN = 2'd2} mode_t;

   state_t              state, state_n;
   mode_t               mode_q;
   logic [2:0][VW-1:0]  slot;
   logic [1:0]          vcnt;
   logic [1:0]          vcnt_eff;
   logic                parity;
   logic                restart_pending;
   logic                accept, cull, step;
   logic [VW-1:0]       v0, v1, v2;

   // a pending restart makes this FETCH behave as if the primitive were empty
   assign vcnt_eff = restart_pending ? 2'd0 : vcnt;
   assign step     = accept | cull;

   // output ordering; odd strip triangles swap the first two to keep winding
   always_comb begin
      v0 = slot[0];
      v1 = slot[1];
      v2 = slot[2];
      if (mode_q == M_STRIP && parity) begin
         v0 = slot[1];
         v1 = slot[0];
      end
   end

   assign o_x0 = v0[VW-1 -: XW];    assign o_y0 = v0[VW-XW-1 -: XW];
   assign o_x1 = v1[VW-1 -: XW];    assign o_y1 = v1[VW-XW-1 -: XW];
   assign o_x2 = v2[VW-1 -: XW];    assign o_y2 = v2[VW-XW-1 -: XW];
   assign o_z0 = v0[2*UVW +: ZW];   assign o_z1 = v1[2*UVW +: ZW];
   assign o_z2 = v2[2*UVW +: ZW];
   assign o_u0 = v0[UVW +: UVW];    assign o_v0 = v0[0 +: UVW];
   assign o_u1 = v1[UVW +: UVW];    assign o_v1 = v1[0 +: UVW];
   assign o_u2 = v2[UVW +: UVW];    assign o_v2 = v2[0 +: UVW];

   assign o_tri_valid = (state == S_EMIT);

`ifdef ASM_CULL_EN
   localparam int AW = 2*XW+3;
   logic signed [XW:0]     dx1, dy1, dx2, dy2;
   logic signed [2*XW+1:0] p0, p1;
   logic signed [AW-1:0]   area2;
   logic                   drop;
   logic [CNTW-1:0]        cull_count;

   assign dx1   = {o_x1[XW-1], o_x1} - {o_x0[XW-1], o_x0};
   assign dy1   = {o_y1[XW-1], o_y1} - {o_y0[XW-1], o_y0};
   assign dx2   = {o_x2[XW-1], o_x2} - {o_x0[XW-1], o_x0};
   assign dy2   = {o_y2[XW-1], o_y2} - {o_y0[XW-1], o_y0};
   assign p0    = dx1 * dy2;
   assign p1    = dx2 * dy1;
   assign area2 = {p0[2*XW+1], p0} - {p1[2*XW+1], p1};
   // zero area is degenerate, negative is clockwise: both are dropped
   assign drop  = area2[AW-1] || (area2 == '0);
   assign o_cull_count = cull_count;

   // cull statistics counter
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)     cull_count <= '0;
      else if (cull) cull_count <= cull_count + 1'b1;
   end
`else
   assign o_cull_count = '0;
`endif

   // state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= S_FETCH;
      else       state <= state_n;
   end

   // next state, FIFO pop strobe, accept / cull decisions
   always_comb begin
      state_n     = state;
      o_fifo_read = 1'b0;
      accept      = 1'b0;
      cull        = 1'b0;
      case (state)
         S_FETCH: if (!i_fifo_empty) begin
            o_fifo_read = 1'b1;
            state_n     = S_WAIT;
         end
`ifdef ASM_CULL_EN
         S_WAIT:  state_n = (vcnt >= 2'd2) ? S_CULL : S_FETCH;
         S_CULL:  if (drop) begin
            cull    = 1'b1;
            state_n = S_FETCH;
         end else begin
            state_n = S_EMIT;
         end
`else
         S_WAIT:  state_n = (vcnt >= 2'd2) ? S_EMIT : S_FETCH;
`endif
         S_EMIT:  if (!i_raster_busy) begin
            accept  = 1'b1;
            state_n = S_FETCH;
         end
         default: state_n = S_FETCH;
      endcase
   end

   // vertex slots, primitive bookkeeping and triangle counter
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         slot            <= '0;
         vcnt            <= 2'd0;
         parity          <= 1'b0;
         mode_q          <= M_LIST;
         restart_pending <= 1'b0;
         o_tri_count     <= '0;
      end else begin
         restart_pending <= i_restart | (restart_pending & (state != S_FETCH));
         if (state == S_FETCH) begin
            if (restart_pending) begin
               vcnt   <= 2'd0;
               parity <= 1'b0;
            end
            if (vcnt_eff == 2'd0)
               mode_q <= (i_mode == 2'd3) ? M_LIST : mode_t'(i_mode);
         end else if (state == S_WAIT) begin
            case (vcnt)
               2'd0:    slot[0] <= i_fifo_data;
               2'd1:    slot[1] <= i_fifo_data;
               default: slot[2] <= i_fifo_data;
            endcase
            vcnt <= (vcnt == 2'd3) ? 2'd3 : vcnt + 2'd1;
         end else if (step) begin
            case (mode_q)
               M_STRIP: begin
                  slot[0] <= slot[1];
                  slot[1] <= slot[2];
                  vcnt    <= 2'd2;
                  parity  <= ~parity;
               end
               M_FAN: begin
                  slot[1] <= slot[2];
                  vcnt    <= 2'd2;
               end
               default: vcnt <= 2'd0;
            endcase
         end
         if (accept) o_tri_count <= o_tri_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_primitive_assembler.sv
// Scoreboard bench for primitive_assembler: expected triangles are queued as
// vertices are pushed and compared when the rasterizer side accepts them.
module tb_primitive_assembler;

   localparam int VW = 104;
   localparam int TW = 3*VW;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic [VW-1:0] i_fifo_data = '0;
   logic          i_fifo_empty = 1'b1;
   logic          o_fifo_read;
   logic [1:0]    i_mode = 2'd0;
   logic          i_restart = 1'b0;
   logic          o_tri_valid;
   logic          i_raster_busy = 1'b0;
   logic signed [15:0] o_x0, o_y0, o_x1, o_y1, o_x2, o_y2;
   logic [7:0]    o_z0, o_z1, o_z2;
   logic [31:0]   o_u0, o_v0, o_u1, o_v1, o_u2, o_v2;
   logic [15:0]   o_tri_count, o_cull_count;

   primitive_assembler dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_fifo_data(i_fifo_data),
      .i_fifo_empty(i_fifo_empty), .o_fifo_read(o_fifo_read), .i_mode(i_mode),
      .i_restart(i_restart), .o_tri_valid(o_tri_valid), .i_raster_busy(i_raster_busy),
      .o_x0(o_x0), .o_y0(o_y0), .o_x1(o_x1), .o_y1(o_y1), .o_x2(o_x2), .o_y2(o_y2),
      .o_z0(o_z0), .o_z1(o_z1), .o_z2(o_z2),
      .o_u0(o_u0), .o_v0(o_v0), .o_u1(o_u1), .o_v1(o_v1), .o_u2(o_u2), .o_v2(o_v2),
      .o_tri_count(o_tri_count), .o_cull_count(o_cull_count)
   );

   always #5 i_clk = ~i_clk;

   logic [TW-1:0] tri_out;
   assign tri_out = {o_x0, o_y0, o_z0, o_u0, o_v0,
                     o_x1, o_y1, o_z1, o_u1, o_v1,
                     o_x2, o_y2, o_z2, o_u2, o_v2};

   int n_chk = 0, n_fail = 0;
   int exp_tri = 0, exp_cull = 0;
   int rd_cnt = 0, rd_viol = 0;
   logic [VW-1:0] vq[$];
   logic [TW-1:0] exp_q[$];
   logic [VW-1:0] sv [1:9];

   task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [VW-1:0] vtx(input int x, input int y);
      logic [15:0] xs, ys;
      xs = x[15:0];
      ys = y[15:0];
      return {xs, ys, 8'(x*7+y), 32'(x*1000+y), 32'hA500_0000 | 32'(x)};
   endfunction

   function automatic int fx(input logic [VW-1:0] v);
      return int'($signed(v[VW-1 -: 16]));
   endfunction
   function automatic int fy(input logic [VW-1:0] v);
      return int'($signed(v[VW-17 -: 16]));
   endfunction

   // queue an expected triangle; with culling built in, non-CCW ones count as culled
   task automatic push_tri(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [VW-1:0] c);
      int area;
      area = (fx(b)-fx(a))*(fy(c)-fy(a)) - (fx(c)-fx(a))*(fy(b)-fy(a));
`ifdef ASM_CULL_EN
      if (area <= 0) exp_cull++;
      else begin exp_q.push_back({a, b, c}); exp_tri++; end
`else
      if (area == area) begin exp_q.push_back({a, b, c}); exp_tri++; end
`endif
   endtask

   // vertex FIFO with one-cycle registered read data
   always @(posedge i_clk) begin
      if (o_fifo_read) begin
         rd_cnt++;
         if (i_fifo_empty) rd_viol++;
         if (vq.size() > 0) i_fifo_data <= vq.pop_front();
      end
      i_fifo_empty <= (vq.size() == 0);
   end

   // rasterizer side: compare each accepted triangle with the scoreboard
   always @(negedge i_clk) begin
      if (!i_rst && o_tri_valid && !i_raster_busy) begin
         if (exp_q.size() == 0) chk("unexpected_tri", tri_out, '0);
         else chk("tri", tri_out, exp_q.pop_front());
      end
   end

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic new_prim(input logic [1:0] m);
      i_mode = m;
      i_restart = 1'b1;
      cyc();
      i_restart = 1'b0;
      cyc();
      cyc();
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 300 && (exp_q.size() != 0 || vq.size() != 0); i++) cyc();
      for (int i = 0; i < 6; i++) cyc();
      chk(tag, TW'(exp_q.size()), '0);
      chk({tag, "_tri_cnt"}, TW'(o_tri_count), TW'(exp_tri));
      chk({tag, "_cull_cnt"}, TW'(o_cull_count), TW'(exp_cull));
   endtask

   logic [TW-1:0] snap;
   logic [15:0]   cnt0;
   int            rd0, hold_bad;

   initial begin
      for (int k = 1; k <= 9; k++) sv[k] = vtx(k, (k % 2 == 1) ? 10 : 0);
      cyc(); cyc(); cyc();
      chk("rst_valid", TW'(o_tri_valid), '0);
      chk("rst_read", TW'(o_fifo_read), '0);
      chk("rst_tri_cnt", TW'(o_tri_count), '0);
      chk("rst_cull_cnt", TW'(o_cull_count), '0);
      chk("rst_outs", tri_out, '0);
      i_rst = 1'b0;
      cyc();

      // list
      for (int k = 1; k <= 6; k++) vq.push_back(sv[k]);
      push_tri(sv[1], sv[2], sv[3]);
      push_tri(sv[4], sv[5], sv[6]);
      drain("list");

      // strip
      new_prim(2'd1);
      for (int k = 1; k <= 5; k++) vq.push_back(sv[k]);
      push_tri(sv[1], sv[2], sv[3]);
      push_tri(sv[3], sv[2], sv[4]);
      push_tri(sv[3], sv[4], sv[5]);
      drain("strip");

      // fan
      new_prim(2'd2);
      for (int k = 1; k <= 5; k++) vq.push_back(sv[k]);
      push_tri(sv[1], sv[2], sv[3]);
      push_tri(sv[1], sv[3], sv[4]);
      push_tri(sv[1], sv[4], sv[5]);
      drain("fan");

      // backpressure, mode 3 behaves as list
      new_prim(2'd3);
      i_raster_busy = 1'b1;
      for (int k = 1; k <= 6; k++) vq.push_back(sv[k]);
      push_tri(sv[1], sv[2], sv[3]);
      push_tri(sv[4], sv[5], sv[6]);
      for (int i = 0; i < 50 && !o_tri_valid; i++) cyc();
      chk("bp_valid", TW'(o_tri_valid), TW'(1));
      snap = tri_out;
      cnt0 = o_tri_count;
      rd0  = rd_cnt;
      hold_bad = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (!o_tri_valid || tri_out !== snap) hold_bad++;
      end
      chk("bp_hold", TW'(hold_bad), '0);
      chk("bp_reads", TW'(rd_cnt), TW'(rd0));
      chk("bp_cnt_held", TW'(o_tri_count), TW'(cnt0));
      i_raster_busy = 1'b0;
      cyc();
      chk("bp_cnt_inc", TW'(o_tri_count), TW'(cnt0 + 16'd1));
      drain("bp");

      // restart in the middle of a strip
      new_prim(2'd1);
      for (int k = 1; k <= 4; k++) vq.push_back(sv[k]);
      push_tri(sv[1], sv[2], sv[3]);
      push_tri(sv[3], sv[2], sv[4]);
      drain("rs_old");
      new_prim(2'd1);
      for (int k = 7; k <= 9; k++) vq.push_back(sv[k]);
      push_tri(sv[7], sv[8], sv[9]);
      drain("rs_new");

`ifdef ASM_CULL_EN
      new_prim(2'd0);
      vq.push_back(vtx(0, 0)); vq.push_back(vtx(4, 0)); vq.push_back(vtx(0, 4));
      vq.push_back(vtx(0, 0)); vq.push_back(vtx(0, 4)); vq.push_back(vtx(4, 0));
      vq.push_back(vtx(0, 0)); vq.push_back(vtx(1, 1)); vq.push_back(vtx(2, 2));
      push_tri(vtx(0, 0), vtx(4, 0), vtx(0, 4));
      push_tri(vtx(0, 0), vtx(0, 4), vtx(4, 0));
      push_tri(vtx(0, 0), vtx(1, 1), vtx(2, 2));
      drain("cull");
`endif

      // asynchronous reset while a triangle is held in EMIT
      new_prim(2'd0);
      i_raster_busy = 1'b1;
      for (int k = 1; k <= 3; k++) vq.push_back(sv[k]);
      push_tri(sv[1], sv[2], sv[3]);
      for (int i = 0; i < 50 && !o_tri_valid; i++) cyc();
      chk("ar_valid_before", TW'(o_tri_valid), TW'(1));
      #2 i_rst = 1'b1;
      #1;
      chk("ar_valid", TW'(o_tri_valid), '0);
      chk("ar_tri_cnt", TW'(o_tri_count), '0);
      chk("ar_outs", tri_out, '0);
      exp_q.delete();
      exp_tri = 0;
      exp_cull = 0;
      i_raster_busy = 1'b0;
      cyc(); cyc();
      i_rst = 1'b0;
      cyc();
      i_mode = 2'd0;
      cyc();
      for (int k = 4; k <= 6; k++) vq.push_back(sv[k]);
      push_tri(sv[4], sv[5], sv[6]);
      drain("ar_recover");

      chk("read_while_empty", TW'(rd_viol), '0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
